seg_reader: RTL and testbench

SEG_READER -- requirements
Module: seg_reader

---
 rtl/seg_reader.sv | 181 ++++++++++++++++++
 tb/tb_seg_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_reader.sv
// seg_reader: scans six 7-segment patterns on tick strobes and decodes them into a 24-bit word.
// Optional SEG_READER_ERRCNT_EN adds a saturating err_count of captures containing illegal glyphs.
`default_nettype none

module seg_reader (
  input  logic        op_clock,
  input  logic        op_reset,
  input  logic        tick,
  input  logic        start,
  input  logic [6:0]  hex0,
  input  logic [6:0]  hex1,
  input  logic [6:0]  hex2,
  input  logic [6:0]  hex3,
  input  logic [6:0]  hex4,
  input  logic [6:0]  hex5,
  output logic        busy,
  output logic [23:0] value,
  output logic        value_valid,
  input  logic        value_ready,
  output logic        err
`ifdef SEG_READER_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] LAST_IDX = 3'd5;

  logic [1:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] acc_q, acc_d;
  logic        acc_err_q, acc_err_d;
  logic [23:0] value_q, value_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d;

  logic [6:0]  cur_pat;
  logic [3:0]  cur_nib;
  logic        cur_bad;

  // Returns {illegal, nibble}; illegal patterns decode to nibble 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    cur_pat = hex0;
    case (idx_q)
      3'd0:    cur_pat = hex0;
      3'd1:    cur_pat = hex1;
      3'd2:    cur_pat = hex2;
      3'd3:    cur_pat = hex3;
      3'd4:    cur_pat = hex4;
      3'd5:    cur_pat = hex5;
      default: cur_pat = hex0;
    endcase
  end

  assign {cur_bad, cur_nib} = seg_decode(cur_pat);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    acc_err_d = acc_err_q;
    value_d   = value_q;
    err_d     = err_q;
    valid_d   = valid_q;
    case (state_q)
      S_IDLE: begin
        // A tick coinciding with start is deliberately not sampled.
        if (start) begin
          state_d   = S_SCAN;
          idx_d     = 3'd0;
          acc_d     = 24'h0;
          acc_err_d = 1'b0;
        end
      end
      S_SCAN: begin
        if (tick) begin
          acc_d[{idx_q, 2'b00} +: 4] = cur_nib;
          acc_err_d = acc_err_q | cur_bad;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            value_d = acc_d;
            err_d   = acc_err_d;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        if (value_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge op_clock or negedge op_reset) begin
    if (!op_reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      acc_q     <= 24'h0;
      acc_err_q <= 1'b0;
      value_q   <= 24'h0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      acc_err_q <= acc_err_d;
      value_q   <= value_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
    end
  end

`ifdef SEG_READER_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;
  logic       done_entry;

  assign done_entry = (state_q == S_SCAN) && (state_d == S_DONE);

  always_comb begin
    err_count_d = err_count_q;
    if (done_entry && err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge op_clock or negedge op_reset) begin
    if (!op_reset) begin
      err_count_q <= 8'h0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

  assign busy        = (state_q == S_SCAN) || (state_q == S_DONE);
  assign value       = value_q;
  assign err         = err_q;
  assign value_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_reader.sv
// tb_seg_reader: table-driven directed checks for seg_reader plus hand-written corner sequences.
`default_nettype none

module tb_seg_reader;

  logic        op_clock = 1'b0;
  logic        op_reset = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  hex0 = 7'h7F, hex1 = 7'h7F, hex2 = 7'h7F, hex3 = 7'h7F, hex4 = 7'h7F, hex5 = 7'h7F;
  logic        busy;
  logic [23:0] value;
  logic        value_valid;
  logic        value_ready = 1'b0;
  logic        err;
`ifdef SEG_READER_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  seg_reader dut (
    .op_clock    (op_clock),
    .op_reset    (op_reset),
    .tick        (tick),
    .start       (start),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .hex4        (hex4),
    .hex5        (hex5),
    .busy        (busy),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .err         (err)
`ifdef SEG_READER_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 op_clock = ~op_clock;

  typedef struct {
    logic [5:0][6:0] hex;
    logic [23:0]     val;
    logic            bad;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge op_clock);
      #1;
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic set_hex(input logic [5:0][6:0] h);
    hex0 = h[0]; hex1 = h[1]; hex2 = h[2];
    hex3 = h[3]; hex4 = h[4]; hex5 = h[5];
  endtask

  task automatic handshake();
    value_ready = 1'b1;
    cyc(1);
    value_ready = 1'b0;
  endtask

  task automatic chk_cnt(input string name);
`ifdef SEG_READER_ERRCNT_EN
    chk(name, {24'h0, err_count}, exp_cnt);
`endif
  endtask

  function automatic vec_t mk(input logic [41:0] h, input logic [23:0] v, input logic b);
    vec_t r;
    r.hex = h;
    r.val = v;
    r.bad = b;
    return r;
  endfunction

  initial begin
    logic [23:0] last_val;

    vecs[0] = mk({7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 24'h543210, 1'b0);
    vecs[1] = mk({7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}, 24'hFEDCBA, 1'b0);
    vecs[2] = mk({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F}, 24'h000000, 1'b1);
    vecs[3] = mk({7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10}, 24'h456789, 1'b0);
    vecs[4] = mk({7'h12, 7'h19, 7'h55, 7'h30, 7'h24, 7'h79}, 24'h540321, 1'b1);
    vecs[5] = mk({7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E}, 24'hFFFFFF, 1'b0);

    // Reset state
    cyc(2);
    chk("rst_value", value, 24'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_valid", value_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk_cnt("rst_errcnt");
    op_reset = 1'b1;
    cyc(1);

    // Tick in IDLE does nothing
    pulse_tick();
    chk("idle_tick_busy", busy, 1'b0);

    last_val = 24'h0;
    for (int i = 0; i < 6; i++) begin
      set_hex(vecs[i].hex);
      pulse_start();
      chk($sformatf("v%0d_busy_start", i), busy, 1'b1);
      for (int k = 0; k < 6; k++) begin
        cyc(i % 3);
        pulse_tick();
        if (k == 2) begin
          chk($sformatf("v%0d_hold_mid", i), value, last_val);
        end
        if (k == 4) begin
          chk($sformatf("v%0d_valid_t5", i), value_valid, 1'b0);
        end
      end
      if (vecs[i].bad) exp_cnt++;
      chk($sformatf("v%0d_value", i), value, vecs[i].val);
      chk($sformatf("v%0d_err", i), err, vecs[i].bad);
      chk($sformatf("v%0d_valid", i), value_valid, 1'b1);
      chk($sformatf("v%0d_busy", i), busy, 1'b1);
      chk_cnt($sformatf("v%0d_errcnt", i));
      handshake();
      chk($sformatf("v%0d_valid_after", i), value_valid, 1'b0);
      chk($sformatf("v%0d_busy_after", i), busy, 1'b0);
      chk($sformatf("v%0d_value_kept", i), value, vecs[i].val);
      last_val = vecs[i].val;
    end

    // DONE held 20 cycles with ticks, starts and changing hex
    set_hex(vecs[0].hex);
    pulse_start();
    repeat (6) pulse_tick();
    set_hex({6{7'h7F}});
    for (int c = 0; c < 20; c++) begin
      tick = (c % 2 == 0);
      start = (c % 3 == 0);
      cyc(1);
    end
    tick = 1'b0;
    start = 1'b0;
    chk("hold_value", value, 24'h543210);
    chk("hold_err", err, 1'b0);
    chk("hold_valid", value_valid, 1'b1);
    chk("hold_busy", busy, 1'b1);
    handshake();
    chk("hold_rel_valid", value_valid, 1'b0);
    chk("hold_rel_busy", busy, 1'b0);
    pulse_start();
    chk("restart_busy", busy, 1'b1);
    repeat (6) pulse_tick();
    exp_cnt++;
    chk("restart_value", value, 24'h0);
    chk("restart_err", err, 1'b1);
    chk_cnt("restart_errcnt");
    handshake();

    // Asynchronous reset mid-scan
    set_hex(vecs[1].hex);
    pulse_start();
    repeat (3) pulse_tick();
    #2;
    op_reset = 1'b0;
    exp_cnt = 0;
    #1;
    chk("arst_value", value, 24'h0);
    chk("arst_err", err, 1'b0);
    chk("arst_valid", value_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk_cnt("arst_errcnt");
    cyc(2);
    op_reset = 1'b1;
    cyc(1);
    pulse_start();
    repeat (5) pulse_tick();
    chk("arst_t5_valid", value_valid, 1'b0);
    chk("arst_t5_busy", busy, 1'b1);
    pulse_tick();
    chk("arst_t6_valid", value_valid, 1'b1);
    chk("arst_t6_value", value, 24'hFEDCBA);
    handshake();

    // Start and tick together: that tick is not sampled
    set_hex(vecs[5].hex);
    start = 1'b1;
    tick = 1'b1;
    cyc(1);
    start = 1'b0;
    tick = 1'b0;
    chk("st_busy", busy, 1'b1);
    repeat (5) pulse_tick();
    chk("st_t5_valid", value_valid, 1'b0);
    chk("st_t5_busy", busy, 1'b1);
    chk("st_t5_value_held", value, 24'hFEDCBA);
    pulse_tick();
    chk("st_t6_valid", value_valid, 1'b1);
    chk("st_t6_value", value, 24'hFFFFFF);
    handshake();

`ifdef SEG_READER_ERRCNT_EN
    // Saturation of the error counter
    set_hex(vecs[2].hex);
    for (int n = 0; n < 300; n++) begin
      pulse_start();
      repeat (6) pulse_tick();
      if (exp_cnt < 255) exp_cnt++;
      handshake();
    end
    chk_cnt("sat_errcnt");
    chk("sat_errcnt_255", {24'h0, err_count}, 32'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
